bcd_mod_cnt: RTL and testbench

Parametrised two-digit BCD modulo counter. It is the general successor to the clock's hour/minute/second counters.
- Counts directly in BCD with a configurable modulus.
- Supports up/down manual setting, parallel load with validation, and a registered carry/borrow for cascading.
- When built as an hour counter, adds a selectable 12-hour display with a PM flag.
- Sits in the time-keeping chain between the lower-digit counter (EN source) and the display decoder (QH/QL).

---
 rtl/bcd_mod_cnt_pkg.sv | 14 +
 rtl/bcd_disp12.sv | 53 +++++
 rtl/bcd_mod_cnt.sv | 132 +++++++++++++
 tb/tb_bcd_mod_cnt.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_mod_cnt_pkg.sv
// Shared constants and helpers for the BCD modulo counter family.
// Digit limits, hour constants and the parallel-load legality check.
package bcd_mod_cnt_pkg;

  localparam int BCD_MAX  = 9;
  localparam int H24_MOD  = 24;
  localparam int H12_NOON = 12;

  // A load is accepted only if both digits are BCD and the value is below the modulus.
  function automatic logic ld_legal(input int qh, input int ql, input int modv);
    return (qh <= BCD_MAX) && (ql <= BCD_MAX) && ((10 * qh + ql) < modv);
  endfunction

endpackage

// File: rtl/bcd_disp12.sv
// Combinational 24-hour to 12-hour BCD display conversion.
// Maps 00..23 to 12,01..11,12,01..11 with a PM flag, working on digits directly.
module bcd_disp12
  import bcd_mod_cnt_pkg::*;
#(
  parameter int QH_W = 2
) (
  input  logic [QH_W-1:0] t,
  input  logic [3:0]      u,
  output logic [QH_W-1:0] qh,
  output logic [3:0]      ql,
  output logic            pm
);

  always_comb begin
    qh = '0;
    ql = u;
    pm = 1'b0;
    case (t)
      QH_W'(0): begin
        if (u == 4'd0) begin
          qh = QH_W'(1);
          ql = 4'd2;
        end
      end
      QH_W'(1): begin
        if (u <= 4'd1) begin
          qh = QH_W'(1);
        end else if (u == 4'd2) begin
          qh = QH_W'(1);
          pm = 1'b1;
        end else begin
          ql = u - 4'd2;
          pm = 1'b1;
        end
      end
      QH_W'(2): begin
        pm = 1'b1;
        // 20,21 -> 08,09 ; 22,23 -> 10,11
        if (u <= 4'd1) begin
          ql = u + 4'd8;
        end else begin
          qh = QH_W'(1);
          ql = u - 4'd2;
        end
      end
      default: begin
        qh = t;
      end
    endcase
  end

endmodule

// File: rtl/bcd_mod_cnt.sv
// Two-digit BCD modulo counter with manual set, validated load, registered carry/borrow
// and an optional 12-hour display decode when built as an hour counter.
module bcd_mod_cnt
  import bcd_mod_cnt_pkg::*;
#(
  parameter int MOD       = 24,
  parameter int QH_W      = 2,
  parameter bit ALLOW_12H = 1'b1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            EN,
  input  logic            INC,
  input  logic            DEC,
  input  logic            LD,
  input  logic [QH_W-1:0] LD_QH,
  input  logic [3:0]      LD_QL,
  input  logic            MODE12,
  output logic [QH_W-1:0] QH,
  output logic [3:0]      QL,
  output logic            PM,
  output logic            CO,
  output logic            BO,
  output logic            LD_ERR
);

  localparam logic [QH_W-1:0] T_MAX   = QH_W'((MOD - 1) / 10);
  localparam logic [3:0]      U_MAX   = 4'((MOD - 1) % 10);
  localparam logic [3:0]      U_DIGIT = 4'(BCD_MAX);

  logic [QH_W-1:0] t_p0, t_nxt;
  logic [3:0]      u_p0, u_nxt;
  logic            co_p0, co_nxt;
  logic            bo_p0, bo_nxt;
  logic            le_p0, le_nxt;
  logic            up, dn, at_top, at_zero, ld_ok;

  always_comb begin
    up      = (EN | INC) & ~DEC;
    dn      = DEC & ~(EN | INC);
    at_top  = (t_p0 == T_MAX) && (u_p0 == U_MAX);
    at_zero = (t_p0 == '0) && (u_p0 == 4'd0);
    ld_ok   = ld_legal(int'(LD_QH), int'(LD_QL), MOD);

    t_nxt  = t_p0;
    u_nxt  = u_p0;
    co_nxt = 1'b0;
    bo_nxt = 1'b0;
    le_nxt = 1'b0;

    if (LD) begin
      le_nxt = ~ld_ok;
      if (ld_ok) begin
        t_nxt = LD_QH;
        u_nxt = LD_QL;
      end
    end else if (up) begin
      // Only the chained tick propagates a carry; manual setting never does.
      co_nxt = at_top & EN;
      if (at_top) begin
        t_nxt = '0;
        u_nxt = 4'd0;
      end else if (u_p0 == U_DIGIT) begin
        t_nxt = t_p0 + QH_W'(1);
        u_nxt = 4'd0;
      end else begin
        u_nxt = u_p0 + 4'd1;
      end
    end else if (dn) begin
      bo_nxt = at_zero;
      if (at_zero) begin
        t_nxt = T_MAX;
        u_nxt = U_MAX;
      end else if (u_p0 == 4'd0) begin
        t_nxt = t_p0 - QH_W'(1);
        u_nxt = U_DIGIT;
      end else begin
        u_nxt = u_p0 - 4'd1;
      end
    end
  end

  // Stage p0: count digits and single-cycle status pulses
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      t_p0  <= '0;
      u_p0  <= 4'd0;
      co_p0 <= 1'b0;
      bo_p0 <= 1'b0;
      le_p0 <= 1'b0;
    end else begin
      t_p0  <= t_nxt;
      u_p0  <= u_nxt;
      co_p0 <= co_nxt;
      bo_p0 <= bo_nxt;
      le_p0 <= le_nxt;
    end
  end

  assign CO     = co_p0;
  assign BO     = bo_p0;
  assign LD_ERR = le_p0;

  generate
    if (ALLOW_12H && (MOD == H24_MOD)) begin : g_disp12
      logic [QH_W-1:0] qh12;
      logic [3:0]      ql12;
      logic            pm12;

      bcd_disp12 #(
        .QH_W (QH_W)
      ) u_disp12 (
        .t  (t_p0),
        .u  (u_p0),
        .qh (qh12),
        .ql (ql12),
        .pm (pm12)
      );

      assign QH = MODE12 ? qh12 : t_p0;
      assign QL = MODE12 ? ql12 : u_p0;
      assign PM = MODE12 & pm12;
    end else begin : g_disp24
      logic unused_mode12;
      assign unused_mode12 = MODE12;
      assign QH = t_p0;
      assign QL = u_p0;
      assign PM = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_bcd_mod_cnt.sv
// Scoreboard bench: an hour counter (MOD=24, 12h capable) and a minute counter (MOD=60)
// share stimulus; an integer reference model predicts every display/pulse after each edge.
module tb_bcd_mod_cnt;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, inc, dec, ld, mode12;
  logic [2:0] ld_qh;
  logic [3:0] ld_ql;

  logic [1:0] qh24;
  logic [3:0] ql24;
  logic       pm24, co24, bo24, le24;
  logic [2:0] qh60;
  logic [3:0] ql60;
  logic       pm60, co60, bo60, le60;

  always #5 clk = ~clk;

  bcd_mod_cnt #(.MOD(24), .QH_W(2), .ALLOW_12H(1'b1)) dut24 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .INC(inc), .DEC(dec), .LD(ld),
    .LD_QH(ld_qh[1:0]), .LD_QL(ld_ql), .MODE12(mode12),
    .QH(qh24), .QL(ql24), .PM(pm24), .CO(co24), .BO(bo24), .LD_ERR(le24)
  );

  bcd_mod_cnt #(.MOD(60), .QH_W(3), .ALLOW_12H(1'b1)) dut60 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .INC(inc), .DEC(dec), .LD(ld),
    .LD_QH(ld_qh), .LD_QL(ld_ql), .MODE12(mode12),
    .QH(qh60), .QL(ql60), .PM(pm60), .CO(co60), .BO(bo60), .LD_ERR(le60)
  );

  typedef struct {
    string       tag;
    logic [10:0] e24;
    logic [10:0] e60;
  } exp_t;

  exp_t q[$];
  int   n_err = 0;
  int   n_chk = 0;

  // reference model state: plain integer counts and last-edge pulses
  int   c24, c60;
  bit   co24_m, bo24_m, le24_m, co60_m, bo60_m, le60_m;
  bit   want_m12;

  task automatic step(inout int c, output bit co, output bit bo, output bit le,
                      input int modv, input int lqh);
    co = 0; bo = 0; le = 0;
    if (ld) begin
      if (lqh <= 9 && int'(ld_ql) <= 9 && (10 * lqh + int'(ld_ql)) < modv) c = 10 * lqh + int'(ld_ql);
      else le = 1;
    end else if ((en || inc) && !dec) begin
      co = (c == modv - 1) && en;
      c  = (c + 1) % modv;
    end else if (dec && !(en || inc)) begin
      bo = (c == 0);
      c  = (c + modv - 1) % modv;
    end
  endtask

  task automatic model_reset();
    c24 = 0; c60 = 0;
    {co24_m, bo24_m, le24_m, co60_m, bo60_m, le60_m} = '0;
  endtask

  task automatic model_edge();
    if (!rst_n) model_reset();
    else begin
      step(c24, co24_m, bo24_m, le24_m, 24, int'(ld_qh[1:0]));
      step(c60, co60_m, bo60_m, le60_m, 60, int'(ld_qh));
    end
  endtask

  function automatic logic [10:0] disp24(int c, bit m12, bit co, bit bo, bit le);
    int d;
    bit p;
    if (m12) begin
      d = (c % 12 == 0) ? 12 : (c % 12);
      p = (c >= 12);
    end else begin
      d = c;
      p = 0;
    end
    return {1'b0, 2'(d / 10), 4'(d % 10), p, co, bo, le};
  endfunction

  function automatic logic [10:0] disp60(int c, bit co, bit bo, bit le);
    return {3'(c / 10), 4'(c % 10), 1'b0, co, bo, le};
  endfunction

  task automatic push(input string tag);
    exp_t e;
    e.tag = tag;
    e.e24 = disp24(c24, mode12, co24_m, bo24_m, le24_m);
    e.e60 = disp60(c60, co60_m, bo60_m, le60_m);
    q.push_back(e);
  endtask

  // one clock edge with the given inputs; the display mode for the check follows the edge
  task automatic drive(input logic e, input logic i, input logic d, input logic l,
                       input logic [2:0] lh, input logic [3:0] lu, input string tag);
    en = e; inc = i; dec = d; ld = l; ld_qh = lh; ld_ql = lu;
    @(posedge clk);
    #1;
    model_edge();
    en = 0; inc = 0; dec = 0; ld = 0;
    mode12 = want_m12;
    push(tag);
  endtask

  task automatic do_rst(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    rst_n = 1'b0;
    model_reset();
    push({tag, "_assert"});
    @(posedge clk);
    #1;
    model_edge();
    rst_n = 1'b1;
    push({tag, "_release"});
  endtask

  task automatic chk(input string nm, input logic [10:0] got, input logic [10:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got{qh,ql,pm,co,bo,lderr}=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, "/h24"}, {1'b0, qh24, ql24, pm24, co24, bo24, le24}, e.e24);
      chk({e.tag, "/m60"}, {qh60, ql60, pm60, co60, bo60, le60}, e.e60);
    end
  end

  initial begin
    rst_n = 1'b0; en = 0; inc = 0; dec = 0; ld = 0; mode12 = 0;
    ld_qh = '0; ld_ql = '0; want_m12 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    push("reset24");
    want_m12 = 1;
    drive(1, 0, 0, 0, 0, 0, "reset12_en_ignored");
    rst_n = 1'b1;
    want_m12 = 0;

    for (int k = 0; k < 24; k++) drive(1, 0, 0, 0, 0, 0, "en_count");
    drive(0, 0, 0, 1, 2, 3, "load23");
    drive(0, 1, 0, 0, 0, 0, "inc_wrap_no_co");
    drive(0, 0, 1, 0, 0, 0, "dec_wrap_bo");
    drive(0, 0, 0, 0, 0, 0, "bo_one_cycle");
    drive(0, 0, 0, 1, 0, 0, "load00");
    drive(0, 0, 1, 0, 0, 0, "dec_wrap_both");
    drive(0, 0, 0, 1, 2, 5, "load25");
    drive(0, 0, 0, 1, 1, 9, "load19");
    drive(1, 1, 0, 1, 0, 4, "load_beats_en");
    drive(0, 0, 0, 1, 0, 10, "load_bad_units");

    want_m12 = 1;
    drive(0, 0, 0, 1, 0, 0, "m12_00");
    drive(0, 0, 0, 1, 1, 2, "m12_12");
    drive(0, 0, 0, 1, 1, 3, "m12_13");
    drive(0, 0, 0, 1, 2, 3, "m12_23");
    want_m12 = 0;
    drive(0, 0, 0, 0, 0, 0, "m12_off");

    drive(0, 0, 0, 1, 0, 7, "load07");
    drive(1, 0, 1, 0, 0, 0, "en_dec_hold");
    drive(1, 1, 0, 0, 0, 0, "en_inc_single");

    drive(0, 0, 0, 1, 5, 9, "load59");
    drive(1, 0, 0, 0, 0, 0, "m60_wrap_co");
    drive(0, 0, 0, 1, 3, 7, "load37");
    do_rst("midreset");
    drive(1, 0, 0, 0, 0, 0, "resume1");
    drive(1, 0, 0, 0, 0, 0, "resume2");

    for (int k = 0; k < 400; k++) begin
      logic [31:0] r;
      r = $urandom;
      if (r[20:16] == 0) want_m12 = ~want_m12;
      if (r[31:26] == 0) do_rst("rnd_reset");
      else drive(r[0], r[3:1] == 0, r[6:4] == 0, r[10:7] == 0,
                 3'($urandom_range(0, 7)), 4'($urandom_range(0, 11)), "random");
    end

    for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
